regfile_mp: RTL and testbench

//  Parametrised multi-port register file for the RISC-V datapath; successor to the 2R/1W regfile.

---
 rtl/regfile_mp_pkg.sv | 14 +
 rtl/regfile_wr_merge.sv | 47 ++++
 rtl/regfile_mp.sv | 103 ++++++++++
 tb/tb_regfile_mp.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: the zero-register address
// and the address-legality rule used by the write merge, the read path and the scoreboard.
package regfile_mp_pkg;

    localparam int unsigned RF_ZERO_ADDR = 0;

    // An address is usable when it maps to a real register and is not the hardwired zero.
    function automatic logic rf_addr_ok(input int unsigned addr,
                                        input int unsigned nregs,
                                        input logic        zero_reg0);
        return (addr < nregs) && !(zero_reg0 && (addr == RF_ZERO_ADDR));
    endfunction

endpackage

// File: rtl/regfile_wr_merge.sv
// Combinational priority merge of the write ports: per-register write enable/data
// and per-read-port forward hit/data. The highest-indexed write port wins on conflict.
module regfile_wr_merge
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned NUM_RD    = 2,
    parameter int unsigned NUM_WR    = 1,
    parameter logic        ZERO_REG0 = 1'b1,
    parameter int unsigned AW        = $clog2(NUM_REGS)
) (
    input  logic [NUM_WR-1:0]             wr_en,
    input  logic [NUM_WR*AW-1:0]          wr_addr,
    input  logic [NUM_WR*DATAWIDTH-1:0]   wr_data,
    input  logic [NUM_RD*AW-1:0]          rd_addr,
    output logic [NUM_REGS-1:0]           reg_we,
    output logic [NUM_REGS*DATAWIDTH-1:0] reg_wdata,
    output logic [NUM_RD-1:0]             fwd_hit,
    output logic [NUM_RD*DATAWIDTH-1:0]   fwd_data
);

    // Ascending port order: a later port simply overwrites an earlier one.
    always_comb begin
        reg_we    = '0;
        reg_wdata = '0;
        fwd_hit   = '0;
        fwd_data  = '0;
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && rf_addr_ok(32'(wr_addr[w*AW +: AW]), NUM_REGS, ZERO_REG0)) begin
                for (int unsigned r = 0; r < NUM_REGS; r++) begin
                    if (wr_addr[w*AW +: AW] == AW'(r)) begin
                        reg_we[r]                         = 1'b1;
                        reg_wdata[r*DATAWIDTH +: DATAWIDTH] = wr_data[w*DATAWIDTH +: DATAWIDTH];
                    end
                end
                for (int unsigned p = 0; p < NUM_RD; p++) begin
                    if (rd_addr[p*AW +: AW] == wr_addr[w*AW +: AW]) begin
                        fwd_hit[p]                          = 1'b1;
                        fwd_data[p*DATAWIDTH +: DATAWIDTH] = wr_data[w*DATAWIDTH +: DATAWIDTH];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: registered reads with write-first forwarding,
// optional hardwired-zero r0, and a per-register busy scoreboard for issue hazards.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned NUM_RD    = 2,
    parameter int unsigned NUM_WR    = 1,
    parameter logic        ZERO_REG0 = 1'b1,
    parameter int unsigned AW        = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_RD-1:0]             rd_en,
    input  logic [NUM_RD*AW-1:0]          rd_addr,
    output logic [NUM_RD*DATAWIDTH-1:0]   rd_data,
    output logic [NUM_RD-1:0]             rd_valid,
    input  logic [NUM_WR-1:0]             wr_en,
    input  logic [NUM_WR*AW-1:0]          wr_addr,
    input  logic [NUM_WR*DATAWIDTH-1:0]   wr_data,
    input  logic                          rsv_en,
    input  logic [AW-1:0]                 rsv_addr,
    output logic [NUM_REGS-1:0]           busy
);

    logic [DATAWIDTH-1:0]          mem [NUM_REGS];
    logic [NUM_REGS-1:0]           reg_we;
    logic [NUM_REGS*DATAWIDTH-1:0] reg_wdata;
    logic [NUM_RD-1:0]             fwd_hit;
    logic [NUM_RD*DATAWIDTH-1:0]   fwd_data;
    logic [NUM_RD*DATAWIDTH-1:0]   rd_next;
    logic                          rsv_ok;

    regfile_wr_merge #(
        .DATAWIDTH (DATAWIDTH),
        .NUM_REGS  (NUM_REGS),
        .NUM_RD    (NUM_RD),
        .NUM_WR    (NUM_WR),
        .ZERO_REG0 (ZERO_REG0),
        .AW        (AW)
    ) u_wr_merge (
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data)
    );

    // Forwarded data takes precedence; illegal and zero addresses read as 0.
    always_comb begin
        rd_next = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            if (fwd_hit[p])
                rd_next[p*DATAWIDTH +: DATAWIDTH] = fwd_data[p*DATAWIDTH +: DATAWIDTH];
            else if (rf_addr_ok(32'(rd_addr[p*AW +: AW]), NUM_REGS, ZERO_REG0))
                rd_next[p*DATAWIDTH +: DATAWIDTH] = mem[rd_addr[p*AW +: AW]];
        end
    end

    always_comb rsv_ok = rsv_en && rf_addr_ok(32'(rsv_addr), NUM_REGS, ZERO_REG0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++)
                mem[r] <= '0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++)
                if (reg_we[r])
                    mem[r] <= reg_wdata[r*DATAWIDTH +: DATAWIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= '0;
        end else begin
            rd_valid <= rd_en;
            for (int unsigned p = 0; p < NUM_RD; p++)
                if (rd_en[p])
                    rd_data[p*DATAWIDTH +: DATAWIDTH] <= rd_next[p*DATAWIDTH +: DATAWIDTH];
        end
    end

    // A new reservation outranks a completing write to the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (rsv_ok && (rsv_addr == AW'(r)))
                    busy[r] <= 1'b1;
                else if (reg_we[r])
                    busy[r] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (24 registers, 2 read / 2 write ports, zero r0):
// the driver pushes reference-model expectations, a monitor pops them on rd_valid.
module tb_regfile_mp;

    localparam int unsigned DW  = 32;
    localparam int unsigned NR  = 24;
    localparam int unsigned NRD = 2;
    localparam int unsigned NWR = 2;
    localparam int unsigned AW  = 5;

    logic                clk;
    logic                rst;
    logic [NRD-1:0]      rd_en;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*DW-1:0]   rd_data;
    logic [NRD-1:0]      rd_valid;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*DW-1:0]   wr_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic [NR-1:0]       busy;

    regfile_mp #(
        .DATAWIDTH (DW),
        .NUM_REGS  (NR),
        .NUM_RD    (NRD),
        .NUM_WR    (NWR),
        .ZERO_REG0 (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] mem_m [NR];
    logic [NR-1:0] busy_m;
    logic [DW-1:0] last_m [NRD];
    logic [DW-1:0] rdq0 [$];
    logic [DW-1:0] rdq1 [$];
    logic [NR-1:0] bq [$];
    bit            mon_on = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bit legal(input int unsigned a);
        return (a < NR) && (a != 0);
    endfunction

    task automatic set_idle();
        rd_en    = '0;
        rd_addr  = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mem_m[i] = '0;
        for (int p = 0; p < NRD; p++) last_m[p] = '0;
        busy_m = '0;
        rdq0.delete();
        rdq1.delete();
        bq.delete();
    endtask

    // Register-file semantics in plain terms: writes land first (later port wins),
    // then reads see the updated file; busy clears on write, set by reservation.
    task automatic issue();
        logic [DW-1:0] nm [NR];
        logic [NR-1:0] nb;
        int unsigned   a;
        for (int i = 0; i < NR; i++) nm[i] = mem_m[i];
        nb = busy_m;
        for (int w = 0; w < NWR; w++) begin
            a = 32'(wr_addr[w*AW +: AW]);
            if (wr_en[w] && legal(a)) begin
                nm[a] = wr_data[w*DW +: DW];
                nb[a] = 1'b0;
            end
        end
        a = 32'(rsv_addr);
        if (rsv_en && legal(a)) nb[a] = 1'b1;
        for (int p = 0; p < NRD; p++) begin
            if (rd_en[p]) begin
                logic [DW-1:0] v;
                a = 32'(rd_addr[p*AW +: AW]);
                v = legal(a) ? nm[a] : '0;
                if (p == 0) rdq0.push_back(v);
                else        rdq1.push_back(v);
            end
        end
        for (int i = 0; i < NR; i++) mem_m[i] = nm[i];
        busy_m = nb;
        bq.push_back(nb);
        mon_on = 1'b1;
    endtask

    task automatic cycle();
        issue();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_on && !rst) begin
            if (bq.size() == 0) begin
                chk("busy_q_empty", 32'd1, 32'd0);
            end else begin
                logic [NR-1:0] eb;
                eb = bq.pop_front();
                chk("busy", 32'(busy), 32'(eb));
            end
            for (int p = 0; p < NRD; p++) begin
                int qs;
                qs = (p == 0) ? rdq0.size() : rdq1.size();
                if (rd_valid[p]) begin
                    if (qs == 0) begin
                        chk("spurious_valid", 32'(p), 32'hFFFF_FFFF);
                    end else begin
                        logic [DW-1:0] e;
                        e = (p == 0) ? rdq0.pop_front() : rdq1.pop_front();
                        last_m[p] = e;
                        chk((p == 0) ? "rd0" : "rd1", rd_data[p*DW +: DW], e);
                    end
                end else begin
                    if (qs != 0) begin
                        chk("missing_valid", 32'(p), 32'hFFFF_FFFF);
                        if (p == 0) void'(rdq0.pop_front());
                        else        void'(rdq1.pop_front());
                    end
                    chk((p == 0) ? "hold0" : "hold1", rd_data[p*DW +: DW], last_m[p]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_rd_data", rd_data[DW-1:0] | rd_data[2*DW-1:DW], '0);
        chk("reset_rd_valid", 32'(rd_valid), '0);
        chk("reset_busy", 32'(busy), '0);
        rst = 1'b0;

        // basic write then read on port 1
        set_idle();
        wr_en = 2'b01; wr_addr[4:0] = 5'd7; wr_data[31:0] = 32'hDEADBEEF;
        cycle();
        set_idle();
        rd_en = 2'b10; rd_addr[9:5] = 5'd7;
        cycle();
        chk("t2_data", rd_data[63:32], 32'hDEADBEEF);
        chk("t2_valid", 32'(rd_valid[1]), 32'd1);

        // forwarding, old value first
        set_idle();
        wr_en = 2'b01; wr_addr[4:0] = 5'd3; wr_data[31:0] = 32'h0000_1111;
        cycle();
        set_idle();
        wr_en = 2'b01; wr_addr[4:0] = 5'd3; wr_data[31:0] = 32'h0000_1234;
        rd_en = 2'b11; rd_addr = {5'd3, 5'd3};
        cycle();
        chk("t3_fwd0", rd_data[31:0], 32'h0000_1234);
        chk("t3_fwd1", rd_data[63:32], 32'h0000_1234);

        // write conflict
        set_idle();
        wr_en = 2'b11; wr_addr = {5'd9, 5'd9}; wr_data = {32'h0000_5555, 32'h0000_AAAA};
        rd_en = 2'b01; rd_addr[4:0] = 5'd9;
        cycle();
        chk("t4_fwd", rd_data[31:0], 32'h0000_5555);
        set_idle();
        rd_en = 2'b10; rd_addr[9:5] = 5'd9;
        cycle();
        chk("t4_store", rd_data[63:32], 32'h0000_5555);

        // zero register
        set_idle();
        wr_en = 2'b01; wr_addr[4:0] = 5'd0; wr_data[31:0] = 32'hFFFF_FFFF;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        rd_en = 2'b01; rd_addr[4:0] = 5'd0;
        cycle();
        chk("t5_fwd_r0", rd_data[31:0], '0);
        chk("t5_busy0", 32'(busy[0]), '0);
        set_idle();
        rd_en = 2'b01; rd_addr[4:0] = 5'd0;
        cycle();
        chk("t5_read_r0", rd_data[31:0], '0);

        // scoreboard
        set_idle();
        rsv_en = 1'b1; rsv_addr = 5'd4;
        cycle();
        chk("t6_rsv", 32'(busy[4]), 32'd1);
        set_idle();
        wr_en = 2'b10; wr_addr[9:5] = 5'd4; wr_data[63:32] = 32'h4444_0000;
        rsv_en = 1'b1; rsv_addr = 5'd4;
        cycle();
        chk("t6_rsv_wins", 32'(busy[4]), 32'd1);
        set_idle();
        wr_en = 2'b01; wr_addr[4:0] = 5'd4; wr_data[31:0] = 32'h4444_0001;
        cycle();
        chk("t6_clear", 32'(busy[4]), '0);

        // out-of-range address
        set_idle();
        wr_en = 2'b01; wr_addr[4:0] = 5'd30; wr_data[31:0] = 32'h3030_3030;
        rsv_en = 1'b1; rsv_addr = 5'd30;
        rd_en = 2'b11; rd_addr = {5'd30, 5'd30};
        cycle();
        chk("oor_fwd", rd_data[31:0], '0);
        set_idle();
        rd_en = 2'b10; rd_addr[9:5] = 5'd30;
        cycle();
        chk("oor_read", rd_data[63:32], '0);

        // randomized traffic; write addresses biased low for conflicts/forwarding
        for (int n = 0; n < 400; n++) begin
            rd_en    = 2'($urandom);
            rd_addr  = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 12))};
            wr_en    = 2'($urandom);
            wr_addr  = {5'($urandom_range(0, 12)), 5'($urandom_range(0, 31))};
            wr_data  = {$urandom, $urandom};
            rsv_en   = ($urandom_range(0, 3) == 0);
            rsv_addr = 5'($urandom_range(0, 25));
            cycle();
        end

        // asynchronous reset with reads in flight
        set_idle();
        wr_en = 2'b01; wr_addr[4:0] = 5'd5; wr_data[31:0] = 32'h5555_ABCD;
        rsv_en = 1'b1; rsv_addr = 5'd6;
        cycle();
        set_idle();
        rd_en = 2'b11; rd_addr = {5'd5, 5'd5};
        cycle();
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_rd_data", rd_data[DW-1:0] | rd_data[2*DW-1:DW], '0);
        chk("mid_rst_rd_valid", 32'(rd_valid), '0);
        chk("mid_rst_busy", 32'(busy), '0);
        mon_on = 1'b0;
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        set_idle();
        rd_en = 2'b11; rd_addr = {5'd5, 5'd5};
        cycle();
        chk("post_rst_r5", rd_data[31:0], '0);

        for (int n = 0; n < 100; n++) begin
            rd_en    = 2'($urandom);
            rd_addr  = {5'($urandom_range(0, 23)), 5'($urandom_range(0, 23))};
            wr_en    = 2'($urandom);
            wr_addr  = {5'($urandom_range(0, 23)), 5'($urandom_range(0, 23))};
            wr_data  = {$urandom, $urandom};
            rsv_en   = 1'($urandom);
            rsv_addr = 5'($urandom_range(0, 23));
            cycle();
        end

        set_idle();
        cycle();
        cycle();
        chk("drain", 32'(rdq0.size() + rdq1.size() + bq.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
